mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequencer for an iterative radix-2 shift-add 64-bit multiply (LEGv8 MUL) resident in the EX stage of the pipelined core. It accepts a multiply when the instruction in EX requests one and runs one shift-add step per cycle. It holds the IF/ID/EX pipeline registers through a stall line until the product is ready, then releases the pipeline with the low N bits of the product. All other EX operations bypass this block and use the single-cycle ALU path.

## Interface
Parameters:
- N, 64, operand and result width; iteration count is N

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mulStart_E  in  1  instruction in EX is a MUL; held high while stalled
- flush_E  in  1  EX instruction squashed (branch taken downstream)
- opA_E  in  N  multiplicand (readData1_E)
- opB_E  in  N  multiplier (readData2_E)
- stall_E  out  1  freeze PC, IF/ID, ID/EX; combinational
- busy_E  out  1  registered; high in BUSY
- done_E  out  1  product valid this cycle; one-cycle pulse
- mulResult_E  out  N  low N bits of opA_E*opB_E; registered

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - if mulStart_E & ~flush_E: at the edge load mcand<=opA_E, mplier<=opB_E, acc<=0, count<=0; go BUSY.
  - otherwise stay in IDLE.
- BUSY, each edge:
  - if mplier[0], acc<=acc+mcand, modulo 2^N with carry discarded
  - mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1
  - when count==N-1, go DONE and register the final acc into mulResult_E.
- DONE: done_E=1; go IDLE at the next edge, unconditionally.
- stall_E = (IDLE & mulStart_E & ~flush_E) | BUSY. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- flush_E in BUSY: return to IDLE at the next edge. mulResult_E is not updated and done_E does not pulse.
- flush_E in DONE is ignored; done_E still pulses. The consumer is expected to squash the result.
- mulStart_E in IDLE on the cycle after DONE is a new multiply (back-to-back). Zero bubble cycles are inserted beyond the state sequence.
- Signed and unsigned operands give identical low-N results; no sign handling.
- mulResult_E holds its value until the next DONE.

## Timing
- Reset values: state IDLE, stall_E 0 (while mulStart_E low), busy_E 0, done_E 0, mulResult_E 0, internal registers 0.
- Asserting reset mid-operation aborts immediately; no result, no done pulse.
- Latency without the feature:
  - start cycle 0 (IDLE, stall_E=1)
  - BUSY cycles 1..N
  - DONE cycle N+1
  - EX occupancy is N+2 cycles (66 for N=64).
- count width is $clog2(N). count wraps only via the state change, never arithmetically.
- Inputs opA_E/opB_E are sampled only at the IDLE->BUSY edge; later changes are ignored.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - BUSY also goes to DONE at the edge where the next mplier value (mplier>>1) is zero.
  - BUSY cycles = max(1, bit length of opB_E).
  - opB_E=0 gives 1 BUSY cycle with result 0.
- Undefined: always exactly N BUSY cycles. Results are identical either way; only latency differs.

## Structure
- Package exec_pkg:
  - typedef enum logic [1:0] mul_state_t {IDLE, BUSY, DONE}
  - localparam MUL_W = 64
- Sub-module mul_step (combinational):
  - inputs acc, mcand, mplier
  - outputs the next acc, mcand and mplier values
  - instantiated once
- State register, counter and stall/done decode live in mul_seq_ctrl.

## Test plan
- opA=3, opB=5, no flush -> stall_E high cycles 0..64, done_E at cycle 65 only, mulResult_E=15 (macro off).
- opA=0xFFFF_FFFF_FFFF_FFFF, opB=0xFFFF_FFFF_FFFF_FFFF -> mulResult_E=1; opA=2^63, opB=2 -> 0 (overflow discarded).
- flush_E at BUSY cycle 10 -> IDLE next edge, stall_E low, no done_E, mulResult_E keeps its previous value.
- reset low at BUSY cycle 20 -> immediate IDLE, all outputs 0; the next multiply 7*6 yields 42 with full latency.
- Back-to-back: 4*4 then 9*9 with mulStart_E high continuously -> done_E pulses at cycles 65 and 131, results 16 then 81.
- MUL_EARLY_EXIT_EN: opB=5 -> 3 BUSY cycles, done_E at cycle 4, result 5*opA; opB=0 -> done_E at cycle 2, result 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared EX-stage types and constants for the iterative multiplier.
package exec_pkg;

  // Operand and result width of the LEGv8 MUL datapath.
  localparam int unsigned MUL_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step: conditionally accumulate, then shift both operands.
module mul_step
  import exec_pkg::*;
#(
  parameter int unsigned N = MUL_W
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] mplier,
  output logic [N-1:0] acc_nxt,
  output logic [N-1:0] mcand_nxt,
  output logic [N-1:0] mplier_nxt
);

  // Carry out of the add is dropped, so the accumulator keeps only the low N bits.
  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage sequencer for the iterative N-bit shift-add multiply.
// Holds the front of the pipeline via stall_E until the product is ready.
// Build option: define MUL_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all zero (same result, shorter latency).
module mul_seq_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned N = MUL_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mulStart_E,
  input  logic         flush_E,
  input  logic [N-1:0] opA_E,
  input  logic [N-1:0] opB_E,
  output logic         stall_E,
  output logic         busy_E,
  output logic         done_E,
  output logic [N-1:0] mulResult_E
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  mul_state_t state_q, state_d;

  logic [N-1:0]    acc_q, mcand_q, mplier_q, result_q;
  logic [N-1:0]    acc_nxt, mcand_nxt, mplier_nxt;
  logic [CntW-1:0] count_q;
  logic            start, last_iter, finish;

  mul_step #(
    .N(N)
  ) u_mul_step (
    .acc       (acc_q),
    .mcand     (mcand_q),
    .mplier    (mplier_q),
    .acc_nxt   (acc_nxt),
    .mcand_nxt (mcand_nxt),
    .mplier_nxt(mplier_nxt)
  );

  // Accept decode and end-of-iteration detection.
  always_comb begin
    start     = mulStart_E & ~flush_E;
    last_iter = (count_q == CntLast);
`ifdef MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: further steps cannot change acc.
    finish    = last_iter | (mplier_nxt == '0);
`else
    finish    = last_iter;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush during BUSY wins over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: begin
        if (flush_E) begin
          state_d = IDLE;
        end else if (finish) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; stall is raised combinationally on the accept cycle.
  always_comb begin
    stall_E = 1'b0;
    busy_E  = 1'b0;
    done_E  = 1'b0;
    case (state_q)
      IDLE: stall_E = start;
      BUSY: begin
        stall_E = 1'b1;
        busy_E  = 1'b1;
      end
      DONE:    done_E = 1'b1;
      default: ;
    endcase
  end

  // Operand load on accept, one shift-add step per BUSY cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (state_q == IDLE && start) begin
      acc_q    <= '0;
      mcand_q  <= opA_E;
      mplier_q <= opB_E;
      count_q  <= '0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_nxt;
      mplier_q <= mplier_nxt;
      // Counter is reloaded by the next accept rather than wrapping.
      if (!last_iter) begin
        count_q <= count_q + CntW'(1);
      end
    end
  end

  // Result register; only a completed, unflushed multiply updates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else if (state_q == BUSY && finish && !flush_E) begin
      result_q <= acc_nxt;
    end
  end

  assign mulResult_E = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: table of directed multiplies plus
// hand-written flush, reset-abort and back-to-back sequences.
module tb_mul_seq_ctrl;
  import exec_pkg::*;

  localparam int unsigned N = MUL_W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mulStart_E = 1'b0;
  logic         flush_E = 1'b0;
  logic [N-1:0] opA_E = '0;
  logic [N-1:0] opB_E = '0;
  logic         stall_E, busy_E, done_E;
  logic [N-1:0] mulResult_E;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(
    .N(N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mulStart_E (mulStart_E),
    .flush_E    (flush_E),
    .opA_E      (opA_E),
    .opB_E      (opB_E),
    .stall_E    (stall_E),
    .busy_E     (busy_E),
    .done_E     (done_E),
    .mulResult_E(mulResult_E)
  );

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] prod;   // low 64 bits of a*b
    int unsigned blen;   // bit length of b
  } vec_t;

  vec_t vecs[7];

  // Expected BUSY cycle count for a multiplier of the given bit length.
  function automatic int unsigned exp_busy(input int unsigned blen);
`ifdef MUL_EARLY_EXIT_EN
    return (blen == 0) ? 1 : blen;
`else
    return N;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one multiply starting at the next edge; cycle 0 is the accept cycle.
  // Operands are scrambled once BUSY to confirm they are not resampled.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input bit hold,
                         output int done_cyc, output int busy_cnt, output int stall_cnt,
                         output logic [63:0] res);
    @(posedge clk);
    #1;
    mulStart_E = 1'b1;
    opA_E      = a;
    opB_E      = b;
    done_cyc   = -1;
    busy_cnt   = 0;
    stall_cnt  = 0;
    res        = '0;
    for (int c = 0; c < 3 * N; c++) begin
      @(negedge clk);
      if (c == 1) begin
        opA_E = ~a;
        opB_E = ~b;
      end
      if (busy_E) busy_cnt++;
      if (stall_E) stall_cnt++;
      if (done_E) begin
        done_cyc = c;
        res      = mulResult_E;
        break;
      end
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      mulStart_E = 1'b0;
    end
  endtask

  initial begin
    int          dc, bc, sc, dc2, eb, eb2;
    logic [63:0] res, prev;
    bit          seen;

    vecs[0] = '{"3x5",      64'd3, 64'd5, 64'd15, 3};
    vecs[1] = '{"ones_sq",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
    vecs[2] = '{"ovf",      64'h8000_0000_0000_0000, 64'd2, 64'd0, 2};
    vecs[3] = '{"7x6",      64'd7, 64'd6, 64'd42, 3};
    vecs[4] = '{"wide",     64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
                64'h0000_0002_0000_0001, 33};
    vecs[5] = '{"mul_zero", 64'h1234, 64'd0, 64'd0, 0};
    vecs[6] = '{"shift16",  64'hDEAD, 64'h10, 64'hD_EAD0, 5};

    // Reset values
    #12;
    check("rst_stall", {63'd0, stall_E}, 64'd0);
    check("rst_busy",  {63'd0, busy_E},  64'd0);
    check("rst_done",  {63'd0, done_E},  64'd0);
    check("rst_result", mulResult_E, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, 1'b0, dc, bc, sc, res);
      eb = exp_busy(vecs[i].blen);
      check({vecs[i].name, "_result"},     res, vecs[i].prod);
      check({vecs[i].name, "_done_cycle"}, dc, eb + 1);
      check({vecs[i].name, "_busy_cycles"}, bc, eb);
      check({vecs[i].name, "_stall_cycles"}, sc, eb + 1);
      @(negedge clk);
      check({vecs[i].name, "_done_single"}, {63'd0, done_E}, 64'd0);
      check({vecs[i].name, "_hold"}, mulResult_E, vecs[i].prod);
    end

    // Flush during BUSY cycle 10
    prev = mulResult_E;
    @(posedge clk);
    #1;
    mulStart_E = 1'b1;
    opA_E      = 64'h55;
    opB_E      = 64'hFFFF;
    repeat (10) @(posedge clk);
    #1;
    flush_E = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {63'd0, busy_E}, 64'd1);
    @(posedge clk);
    #1;
    flush_E    = 1'b0;
    mulStart_E = 1'b0;
    @(negedge clk);
    check("flush_busy_after",  {63'd0, busy_E},  64'd0);
    check("flush_stall_after", {63'd0, stall_E}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done_E) seen = 1'b1;
    end
    check("flush_no_done", {63'd0, seen}, 64'd0);
    check("flush_result_kept", mulResult_E, prev);

    // Reset asserted at BUSY cycle 20
    @(posedge clk);
    #1;
    mulStart_E = 1'b1;
    opA_E      = 64'hFFFF_FFFF_FFFF_FFFF;
    opB_E      = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_busy_before", {63'd0, busy_E}, 64'd1);
    reset      = 1'b0;
    mulStart_E = 1'b0;
    #1;
    check("rstmid_busy",   {63'd0, busy_E},  64'd0);
    check("rstmid_stall",  {63'd0, stall_E}, 64'd0);
    check("rstmid_done",   {63'd0, done_E},  64'd0);
    check("rstmid_result", mulResult_E, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_mul(64'd7, 64'd6, 1'b0, dc, bc, sc, res);
    check("post_rst_result", res, 64'd42);
    check("post_rst_done_cycle", dc, exp_busy(3) + 1);

    // Back-to-back with mulStart_E held high throughout
    run_mul(64'd4, 64'd4, 1'b1, dc, bc, sc, res);
    eb = exp_busy(3);
    check("b2b_first_result", res, 64'd16);
    check("b2b_first_done_cycle", dc, eb + 1);
    run_mul(64'd9, 64'd9, 1'b0, dc2, bc, sc, res);
    eb2 = exp_busy(4);
    check("b2b_second_result", res, 64'd81);
    check("b2b_second_done_cycle", dc + 1 + dc2, (eb + 2) + (eb2 + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
